// File: rtl/rice_core_trap_ctrl.sv
// Machine-mode trap controller: holds the M-mode trap CSRs, decides which
// trap/return event retires each cycle and produces a one-cycle redirect.
module rice_core_trap_ctrl #(
  parameter int               XLEN        = 32,
  parameter int               NUM_IRQ     = 4,
  parameter int               VECTORED    = 1,
  parameter logic [XLEN-1:0]  MTVEC_RESET = '0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_inst_valid,
  input  logic [XLEN-1:0]   i_pc,
  input  logic              i_exception,
  input  logic [4:0]        i_exception_cause,
  input  logic [XLEN-1:0]   i_exception_tval,
  input  logic              i_mret,
  input  logic [NUM_IRQ-1:0] i_irq,
  input  logic              i_csr_we,
  input  logic [11:0]       i_csr_addr,
  input  logic [XLEN-1:0]   i_csr_wdata,
  output logic [XLEN-1:0]   o_csr_rdata,
  output logic              o_trap_valid,
  output logic [XLEN-1:0]   o_trap_pc,
  output logic [XLEN-1:0]   o_return_pc,
  output logic [1:0]        o_privilege_level
);

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MIE     = 12'h304;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;
  localparam logic [11:0] CSR_MIP     = 12'h344;
  localparam int          IRQ_BASE    = 16;
  localparam logic [4:0]  CAUSE_ILLEGAL = 5'd2;

  typedef enum logic [1:0] {
    PRIV_U = 2'b00,
    PRIV_M = 2'b11
  } priv_e;

  priv_e               mode_reg, mode_next;
  priv_e               mpp_reg, mpp_next;
  logic                mstatus_mie_reg, mstatus_mie_next;
  logic                mpie_reg, mpie_next;
  logic [XLEN-1:0]     mie_reg, mie_next;
  logic [XLEN-1:0]     mtvec_reg, mtvec_next;
  logic [XLEN-1:0]     mepc_reg, mepc_next;
  logic [XLEN-1:0]     mcause_reg, mcause_next;
  logic [XLEN-1:0]     mtval_reg, mtval_next;
  logic [NUM_IRQ-1:0]  mip_reg;
  logic                trap_valid_reg, trap_valid_next;
  logic [XLEN-1:0]     trap_pc_reg, trap_pc_next;

  logic [XLEN-1:0]     irq_mask;
  logic [XLEN-1:0]     mip_word;
  logic [XLEN-1:0]     mstatus_word;
  logic [NUM_IRQ-1:0]  irq_pending;
  logic [4:0]          irq_code;
  logic                in_m;
  logic                ext_exc;
  logic                ill_inst;
  logic                take_exc;
  logic                take_irq;
  logic                take_mret;
  logic                take_csr;
  logic [4:0]          trap_code;
  logic [XLEN-1:0]     mtvec_base;
  logic                vectored_mode;

  // Map the local interrupt lines onto their mip/mie bit positions.
  genvar gi;
  generate
    for (gi = 0; gi < XLEN; gi++) begin : g_irq_bits
      if (gi >= IRQ_BASE && gi < IRQ_BASE + NUM_IRQ) begin : g_impl
        assign irq_mask[gi] = 1'b1;
        assign mip_word[gi] = mip_reg[gi-IRQ_BASE];
      end else begin : g_unimpl
        assign irq_mask[gi] = 1'b0;
        assign mip_word[gi] = 1'b0;
      end
    end
  endgenerate

  // Assemble the architectural view of mstatus from its stored fields.
  always_comb begin
    mstatus_word        = '0;
    mstatus_word[3]     = mstatus_mie_reg;
    mstatus_word[7]     = mpie_reg;
    mstatus_word[12:11] = mpp_reg;
  end

  // Combinational CSR read port; unimplemented addresses read zero.
  always_comb begin
    o_csr_rdata = '0;
    case (i_csr_addr)
      CSR_MSTATUS: o_csr_rdata = mstatus_word;
      CSR_MIE:     o_csr_rdata = mie_reg;
      CSR_MTVEC:   o_csr_rdata = mtvec_reg;
      CSR_MEPC:    o_csr_rdata = mepc_reg;
      CSR_MCAUSE:  o_csr_rdata = mcause_reg;
      CSR_MTVAL:   o_csr_rdata = mtval_reg;
      CSR_MIP:     o_csr_rdata = mip_word;
      default:     o_csr_rdata = '0;
    endcase
  end

  // Lowest-numbered enabled pending interrupt wins.
  assign irq_pending = mip_reg & mie_reg[IRQ_BASE +: NUM_IRQ];
  always_comb begin
    irq_code = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (irq_pending[k]) irq_code = 5'(IRQ_BASE + k);
    end
  end

  // Event arbitration: exceptions (incl. illegal mret/CSR access from U)
  // beat interrupts, which beat mret, which beats a CSR write.
  assign in_m      = (mode_reg == PRIV_M);
  assign ext_exc   = i_inst_valid & i_exception;
  assign ill_inst  = (i_inst_valid & i_mret & ~in_m) | (i_csr_we & ~in_m);
  assign take_exc  = ext_exc | ill_inst;
  assign take_irq  = ~take_exc & i_inst_valid & ~i_exception & (|irq_pending)
                   & (mstatus_mie_reg | ~in_m);
  assign take_mret = ~take_exc & ~take_irq & i_inst_valid & i_mret;
  assign take_csr  = ~take_exc & ~take_irq & ~take_mret & i_csr_we;

  assign trap_code     = take_irq ? irq_code : (ext_exc ? i_exception_cause : CAUSE_ILLEGAL);
  assign mtvec_base    = {mtvec_reg[XLEN-1:2], 2'b00};
  assign vectored_mode = (VECTORED != 0) && (mtvec_reg[1:0] == 2'b01);

  // Next-state for every CSR, the privilege mode and the redirect pulse.
  always_comb begin
    mode_next        = mode_reg;
    mpp_next         = mpp_reg;
    mstatus_mie_next = mstatus_mie_reg;
    mpie_next        = mpie_reg;
    mie_next         = mie_reg;
    mtvec_next       = mtvec_reg;
    mepc_next        = mepc_reg;
    mcause_next      = mcause_reg;
    mtval_next       = mtval_reg;
    trap_valid_next  = 1'b0;
    trap_pc_next     = trap_pc_reg;

    if (take_exc || take_irq) begin
      mepc_next        = {i_pc[XLEN-1:2], 2'b00};
      mcause_next      = {take_irq, {(XLEN-6){1'b0}}, trap_code};
      mtval_next       = (take_exc && ext_exc) ? i_exception_tval : '0;
      mpie_next        = mstatus_mie_reg;
      mstatus_mie_next = 1'b0;
      mpp_next         = mode_reg;
      mode_next        = PRIV_M;
      trap_valid_next  = 1'b1;
      if (take_irq && vectored_mode)
        trap_pc_next = mtvec_base + {{(XLEN-7){1'b0}}, trap_code, 2'b00};
      else
        trap_pc_next = mtvec_base;
    end else if (take_mret) begin
      mode_next        = mpp_reg;
      mstatus_mie_next = mpie_reg;
      mpie_next        = 1'b1;
      mpp_next         = PRIV_U;
      trap_valid_next  = 1'b1;
      trap_pc_next     = mepc_reg;
    end else if (take_csr) begin
      case (i_csr_addr)
        CSR_MSTATUS: begin
          mstatus_mie_next = i_csr_wdata[3];
          mpie_next        = i_csr_wdata[7];
          mpp_next         = (i_csr_wdata[12:11] == 2'b11) ? PRIV_M : PRIV_U;
        end
        CSR_MIE:    mie_next    = i_csr_wdata & irq_mask;
        CSR_MTVEC:  mtvec_next  = {i_csr_wdata[XLEN-1:2],
                                   ((VECTORED != 0) && (i_csr_wdata[1:0] == 2'b01)) ? 2'b01 : 2'b00};
        CSR_MEPC:   mepc_next   = {i_csr_wdata[XLEN-1:2], 2'b00};
        CSR_MCAUSE: mcause_next = i_csr_wdata;
        CSR_MTVAL:  mtval_next  = i_csr_wdata;
        default: ;
      endcase
    end
  end

  // State registers; reset clears everything, even mid-redirect.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      mode_reg        <= PRIV_M;
      mpp_reg         <= PRIV_U;
      mstatus_mie_reg <= 1'b0;
      mpie_reg        <= 1'b0;
      mie_reg         <= '0;
      mtvec_reg       <= MTVEC_RESET;
      mepc_reg        <= '0;
      mcause_reg      <= '0;
      mtval_reg       <= '0;
      mip_reg         <= '0;
      trap_valid_reg  <= 1'b0;
      trap_pc_reg     <= '0;
    end else begin
      mode_reg        <= mode_next;
      mpp_reg         <= mpp_next;
      mstatus_mie_reg <= mstatus_mie_next;
      mpie_reg        <= mpie_next;
      mie_reg         <= mie_next;
      mtvec_reg       <= mtvec_next;
      mepc_reg        <= mepc_next;
      mcause_reg      <= mcause_next;
      mtval_reg       <= mtval_next;
      mip_reg         <= i_irq;
      trap_valid_reg  <= trap_valid_next;
      trap_pc_reg     <= trap_pc_next;
    end
  end

  assign o_trap_valid      = trap_valid_reg;
  assign o_trap_pc         = trap_pc_reg;
  assign o_return_pc       = mepc_reg;
  assign o_privilege_level = mode_reg;

endmodule

// File: tb/tb_rice_core_trap_ctrl.sv
// Bench for rice_core_trap_ctrl: WARL vector table, directed trap/mret
// sequences, async reset mid-redirect, and random traffic vs. a model.
module tb_rice_core_trap_ctrl;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_inst_valid;
  logic [31:0] i_pc;
  logic        i_exception;
  logic [4:0]  i_exception_cause;
  logic [31:0] i_exception_tval;
  logic        i_mret;
  logic [3:0]  i_irq;
  logic        i_csr_we;
  logic [11:0] i_csr_addr;
  logic [31:0] i_csr_wdata;
  logic [31:0] o_csr_rdata, o_trap_pc, o_return_pc;
  logic        o_trap_valid;
  logic [1:0]  o_privilege_level;
  logic [31:0] nv_csr_rdata, nv_trap_pc, nv_return_pc;
  logic        nv_trap_valid;
  logic [1:0]  nv_privilege_level;

  int checks = 0;
  int errors = 0;
  int txn    = 0;

  always #5 i_clk = ~i_clk;

  rice_core_trap_ctrl #(.XLEN(32), .NUM_IRQ(4), .VECTORED(1), .MTVEC_RESET(32'h0)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_inst_valid(i_inst_valid), .i_pc(i_pc),
    .i_exception(i_exception), .i_exception_cause(i_exception_cause),
    .i_exception_tval(i_exception_tval), .i_mret(i_mret), .i_irq(i_irq),
    .i_csr_we(i_csr_we), .i_csr_addr(i_csr_addr), .i_csr_wdata(i_csr_wdata),
    .o_csr_rdata(o_csr_rdata), .o_trap_valid(o_trap_valid), .o_trap_pc(o_trap_pc),
    .o_return_pc(o_return_pc), .o_privilege_level(o_privilege_level)
  );

  rice_core_trap_ctrl #(.XLEN(32), .NUM_IRQ(4), .VECTORED(0), .MTVEC_RESET(32'h0)) dut_nv (
    .i_clk(i_clk), .i_rst(i_rst), .i_inst_valid(i_inst_valid), .i_pc(i_pc),
    .i_exception(i_exception), .i_exception_cause(i_exception_cause),
    .i_exception_tval(i_exception_tval), .i_mret(i_mret), .i_irq(i_irq),
    .i_csr_we(i_csr_we), .i_csr_addr(i_csr_addr), .i_csr_wdata(i_csr_wdata),
    .o_csr_rdata(nv_csr_rdata), .o_trap_valid(nv_trap_valid), .o_trap_pc(nv_trap_pc),
    .o_return_pc(nv_return_pc), .o_privilege_level(nv_privilege_level)
  );

  // ---------------- reference model (main, vectored instance) ----------------
  bit          m_user, m_sie, m_mpie, m_tv;
  logic [1:0]  m_mpp;
  logic [31:0] m_mie, m_mtvec, m_mepc, m_mcause, m_mtval, m_trap_pc;
  logic [3:0]  m_mip;

  task automatic model_reset();
    m_user = 0; m_sie = 0; m_mpie = 0; m_mpp = 2'd0; m_tv = 0;
    m_mie = 0; m_mtvec = 0; m_mepc = 0; m_mcause = 0; m_mtval = 0;
    m_trap_pc = 0; m_mip = 0;
  endtask

  function automatic logic [31:0] m_read(input logic [11:0] a);
    case (a)
      12'h300: return (32'(m_mpp) << 11) | (32'(m_mpie) << 7) | (32'(m_sie) << 3);
      12'h304: return m_mie;
      12'h305: return m_mtvec;
      12'h341: return m_mepc;
      12'h342: return m_mcause;
      12'h343: return m_mtval;
      12'h344: return {12'd0, m_mip, 16'd0};
      default: return 32'd0;
    endcase
  endfunction

  // Applies the architectural rules for one clock edge with current inputs.
  task automatic model_step();
    bit is_trap = 0, is_irq = 0;
    int code = 0;
    logic [31:0] tval = 0;
    logic [3:0] pend = m_mip & m_mie[19:16];
    if (i_inst_valid && i_exception) begin
      is_trap = 1; code = int'(i_exception_cause); tval = i_exception_tval;
    end else if ((i_inst_valid && i_mret && m_user) || (i_csr_we && m_user)) begin
      is_trap = 1; code = 2; tval = 0;
    end else if (i_inst_valid && pend != 0 && (m_sie || m_user)) begin
      is_trap = 1; is_irq = 1;
      for (int b = 3; b >= 0; b--) if (pend[b]) code = 16 + b;
    end
    m_tv = 0;
    if (is_trap) begin
      m_mepc   = i_pc & ~32'd3;
      m_mcause = is_irq ? (32'h8000_0000 | 32'(code)) : 32'(code);
      m_mtval  = tval;
      m_mpie   = m_sie; m_sie = 0;
      m_mpp    = m_user ? 2'd0 : 2'd3;
      m_user   = 0;
      m_tv     = 1;
      m_trap_pc = (is_irq && m_mtvec[1:0] == 2'd1) ? ((m_mtvec & ~32'd3) + 32'(4 * code))
                                                   : (m_mtvec & ~32'd3);
    end else if (i_inst_valid && i_mret) begin
      m_tv = 1; m_trap_pc = m_mepc;
      m_user = (m_mpp == 2'd0);
      m_sie = m_mpie; m_mpie = 1; m_mpp = 2'd0;
    end else if (i_csr_we) begin
      case (i_csr_addr)
        12'h300: begin
          m_sie = i_csr_wdata[3]; m_mpie = i_csr_wdata[7];
          m_mpp = (i_csr_wdata[12:11] == 2'd3) ? 2'd3 : 2'd0;
        end
        12'h304: m_mie = i_csr_wdata & 32'h000F_0000;
        12'h305: m_mtvec = {i_csr_wdata[31:2], (i_csr_wdata[1:0] == 2'd1) ? 2'd1 : 2'd0};
        12'h341: m_mepc = i_csr_wdata & ~32'd3;
        12'h342: m_mcause = i_csr_wdata;
        12'h343: m_mtval = i_csr_wdata;
        default: ;
      endcase
    end
    m_mip = i_irq;
  endtask

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    i_inst_valid = 0; i_exception = 0; i_exception_cause = 0; i_exception_tval = 0;
    i_mret = 0; i_csr_we = 0; i_csr_wdata = 0;
  endtask

  // One clock edge: step the model, then compare every output.
  task automatic cycle(input string tag);
    model_step();
    @(posedge i_clk); #1;
    txn++;
    chk({tag, "/trap_valid"}, 32'(o_trap_valid), 32'(m_tv));
    chk({tag, "/trap_pc"}, o_trap_pc, m_trap_pc);
    chk({tag, "/return_pc"}, o_return_pc, m_mepc);
    chk({tag, "/priv"}, 32'(o_privilege_level), m_user ? 32'd0 : 32'd3);
    chk({tag, "/rdata"}, o_csr_rdata, m_read(i_csr_addr));
    $display("txn %0d %s tv=%0b tpc=%h priv=%0d", txn, tag, o_trap_valid, o_trap_pc, o_privilege_level);
  endtask

  task automatic do_reset();
    idle_inputs(); i_irq = 0; i_pc = 0; i_csr_addr = 0;
    i_rst = 1;
    repeat (2) @(posedge i_clk);
    #1;
    model_reset();
    i_rst = 0;
  endtask

  task automatic csr_wr(input logic [11:0] a, input logic [31:0] d);
    idle_inputs();
    i_csr_we = 1; i_csr_addr = a; i_csr_wdata = d;
    cycle("csr_wr");
    i_csr_we = 0;
  endtask

  task automatic rd_chk(input string name, input logic [11:0] a, input logic [31:0] exp);
    i_csr_addr = a; #1;
    chk(name, o_csr_rdata, exp);
  endtask

  typedef struct {
    logic [11:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp;
    logic [31:0] exp_nv;
  } warl_vec_t;

  warl_vec_t vecs [13];
  logic [11:0] addr_pool [8];

  initial begin
    vecs[0]  = '{12'h305, 32'h0000_0203, 32'h0000_0200, 32'h0000_0200};
    vecs[1]  = '{12'h305, 32'h0000_0101, 32'h0000_0101, 32'h0000_0100};
    vecs[2]  = '{12'h305, 32'h0000_0102, 32'h0000_0100, 32'h0000_0100};
    vecs[3]  = '{12'h300, 32'h0000_1000, 32'h0000_0000, 32'h0000_0000};
    vecs[4]  = '{12'h300, 32'h0000_0800, 32'h0000_0000, 32'h0000_0000};
    vecs[5]  = '{12'h300, 32'h0000_1888, 32'h0000_1888, 32'h0000_1888};
    vecs[6]  = '{12'h300, 32'hFFFF_FFFF, 32'h0000_1888, 32'h0000_1888};
    vecs[7]  = '{12'h341, 32'h0001_2347, 32'h0001_2344, 32'h0001_2344};
    vecs[8]  = '{12'h342, 32'h8000_000B, 32'h8000_000B, 32'h8000_000B};
    vecs[9]  = '{12'h343, 32'hCAFE_BABE, 32'hCAFE_BABE, 32'hCAFE_BABE};
    vecs[10] = '{12'h304, 32'hFFFF_FFFF, 32'h000F_0000, 32'h000F_0000};
    vecs[11] = '{12'h344, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    vecs[12] = '{12'h7C0, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0000};
    addr_pool = '{12'h300, 12'h304, 12'h305, 12'h341, 12'h342, 12'h343, 12'h344, 12'h7C0};

    // Reset state.
    do_reset();
    chk("rst/trap_valid", 32'(o_trap_valid), 32'd0);
    chk("rst/trap_pc", o_trap_pc, 32'd0);
    chk("rst/priv", 32'(o_privilege_level), 32'd3);
    rd_chk("rst/mstatus", 12'h300, 32'd0);
    rd_chk("rst/mtvec", 12'h305, 32'd0);

    // WARL table on both builds.
    foreach (vecs[i]) begin
      csr_wr(vecs[i].addr, vecs[i].wdata);
      chk($sformatf("warl%0d", i), o_csr_rdata, vecs[i].exp);
      chk($sformatf("warl%0d_nv", i), nv_csr_rdata, vecs[i].exp_nv);
    end

    // Synchronous exception.
    do_reset();
    csr_wr(12'h305, 32'h100);
    idle_inputs();
    i_inst_valid = 1; i_exception = 1; i_exception_cause = 5'd2;
    i_exception_tval = 32'hDEAD; i_pc = 32'h200;
    cycle("exc");
    chk("exc/valid", 32'(o_trap_valid), 32'd1);
    chk("exc/pc", o_trap_pc, 32'h100);
    chk("exc/mepc", o_return_pc, 32'h200);
    chk("exc/priv", 32'(o_privilege_level), 32'd3);
    idle_inputs();
    rd_chk("exc/mcause", 12'h342, 32'd2);
    rd_chk("exc/mtval", 12'h343, 32'hDEAD);
    cycle("idle");
    chk("exc/pulse_end", 32'(o_trap_valid), 32'd0);

    // Vectored interrupt.
    csr_wr(12'h305, 32'h101);
    csr_wr(12'h304, 32'h0002_0000);
    csr_wr(12'h300, 32'h8);
    i_irq = 4'b0010;
    cycle("irq_sample");
    i_inst_valid = 1; i_pc = 32'h400;
    cycle("irq");
    chk("irq/valid", 32'(o_trap_valid), 32'd1);
    chk("irq/pc", o_trap_pc, 32'h144);
    idle_inputs(); i_irq = 0;
    rd_chk("irq/mcause", 12'h342, 32'h8000_0011);
    rd_chk("irq/mtval", 12'h343, 32'd0);
    rd_chk("irq/mstatus", 12'h300, 32'h1880);
    cycle("idle");

    // mret to U, then illegal mret from U.
    csr_wr(12'h300, 32'h80);
    csr_wr(12'h341, 32'h300);
    i_inst_valid = 1; i_mret = 1; i_pc = 32'h340;
    cycle("mret");
    chk("mret/pc", o_trap_pc, 32'h300);
    chk("mret/priv", 32'(o_privilege_level), 32'd0);
    rd_chk("mret/mstatus", 12'h300, 32'h88);
    i_pc = 32'h500;
    cycle("mret_u");
    chk("mret_u/valid", 32'(o_trap_valid), 32'd1);
    chk("mret_u/pc", o_trap_pc, 32'h100);
    chk("mret_u/priv", 32'(o_privilege_level), 32'd3);
    idle_inputs();
    rd_chk("mret_u/mcause", 12'h342, 32'd2);
    rd_chk("mret_u/mepc", 12'h341, 32'h500);

    // Exception + pending IRQ + CSR write in the same cycle.
    csr_wr(12'h300, 32'h1888);
    i_irq = 4'b0010;
    cycle("irq_sample");
    i_inst_valid = 1; i_exception = 1; i_exception_cause = 5'd5;
    i_exception_tval = 32'h55; i_pc = 32'h600;
    i_csr_we = 1; i_csr_addr = 12'h304; i_csr_wdata = 32'd0;
    cycle("collide");
    chk("collide/pc", o_trap_pc, 32'h100);
    idle_inputs();
    rd_chk("collide/mcause", 12'h342, 32'd5);
    rd_chk("collide/mie", 12'h304, 32'h0002_0000);
    i_inst_valid = 1; i_pc = 32'h604;
    cycle("masked");
    chk("masked/valid", 32'(o_trap_valid), 32'd0);
    i_mret = 1;
    cycle("mret_m");
    chk("mret_m/pc", o_trap_pc, 32'h600);
    i_mret = 0; i_pc = 32'h700;
    cycle("late_irq");
    chk("late_irq/pc", o_trap_pc, 32'h144);
    chk("late_irq/valid", 32'(o_trap_valid), 32'd1);

    // Asynchronous reset while the redirect pulse is high.
    #1 i_rst = 1;
    #1;
    chk("arst/valid", 32'(o_trap_valid), 32'd0);
    chk("arst/trap_pc", o_trap_pc, 32'd0);
    chk("arst/mepc", o_return_pc, 32'd0);
    chk("arst/priv", 32'(o_privilege_level), 32'd3);
    rd_chk("arst/mtvec", 12'h305, 32'd0);
    rd_chk("arst/mstatus", 12'h300, 32'd0);
    rd_chk("arst/mie", 12'h304, 32'd0);
    rd_chk("arst/mcause", 12'h342, 32'd0);
    do_reset();

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      i_inst_valid      = ($urandom_range(0, 3) != 0);
      i_exception       = ($urandom_range(0, 7) == 0);
      i_exception_cause = 5'($urandom);
      i_exception_tval  = $urandom;
      i_pc              = $urandom;
      i_mret            = ($urandom_range(0, 6) == 0);
      i_irq             = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
      i_csr_we          = ($urandom_range(0, 4) == 0);
      i_csr_addr        = addr_pool[$urandom_range(0, 7)];
      i_csr_wdata       = $urandom;
      cycle("rand");
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
